// File: rtl/priority_decoder.sv
// Receive side of the priority-encoder link: buffers {code, any} transfers in a
// small FIFO and regenerates the one-hot request vector at the head.
module priority_decoder #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      in_code,
  input  logic                   in_any,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<CODE_W)-1:0] out_onehot,
  output logic                   out_any,
  output logic [CNT_W-1:0]       zero_cnt
);

  localparam int OUT_W    = 1 << CODE_W;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              any;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_W-1:0]    zero_cnt_q, zero_cnt_d;
  entry_t              head;
  logic                push;
  logic                pop;

  // Handshakes depend only on the registered count, so a pop never opens a
  // same-cycle push slot when the FIFO is full.
  assign in_ready  = (count_q != CNT_BITS'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_any   = out_valid && head.any;
  assign zero_cnt  = zero_cnt_q;

  always_comb begin
    out_onehot = '0;
    if (out_valid && head.any) begin
      out_onehot = OUT_W'(1) << head.code;
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    zero_cnt_d = zero_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_code, in_any};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (!head.any && (zero_cnt_q != '1)) begin
        zero_cnt_d = zero_cnt_q + CNT_W'(1);
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      zero_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

endmodule

// File: tb/tb_priority_decoder.sv
// Directed self-checking bench for priority_decoder (CODE_W=2, DEPTH=2, CNT_W=2).
module tb_priority_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       in_any;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_onehot;
  logic       out_any;
  logic [1:0] zero_cnt;

  int checks;
  int errors;

  priority_decoder #(.CODE_W(2), .DEPTH(2), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_any     (in_any),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_any    (out_any),
    .zero_cnt   (zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] code,
                               input logic any, input logic ready);
    in_valid  = valid;
    in_code   = code;
    in_any    = any;
    out_ready = ready;
  endtask

  logic [1:0] str_code [100];
  logic       str_any  [100];
  int         exp_zero;
  logic [3:0] exp_oh;
  logic [1:0] sat_tab [5];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    $display("[TB] reset behaviour");
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_onehot", out_onehot, 0);
    checkOutput("rst_zero_cnt", zero_cnt, 0);

    // fill to count=2, then reset asynchronously mid-cycle
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_onehot", out_onehot, 4'b1000);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_out_valid", out_valid, 0);
    checkOutput("async_onehot", out_onehot, 0);
    checkOutput("async_zero_cnt", zero_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checkOutput("release_in_ready", in_ready, 1);
    checkOutput("release_out_valid", out_valid, 0);

    $display("[TB] decode sweep");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b1, 1'b1);
      tick();
      checkOutput("sweep_valid", out_valid, 1);
      checkOutput("sweep_onehot", out_onehot, 32'(1 << i));
      checkOutput("sweep_any", out_any, 1);
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("sweep_drained", out_valid, 0);

    $display("[TB] any=0 transfer");
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    checkOutput("zero_valid", out_valid, 1);
    checkOutput("zero_onehot", out_onehot, 0);
    checkOutput("zero_any", out_any, 0);
    checkOutput("zero_cnt_before", zero_cnt, 0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("zero_cnt_after", zero_cnt, 1);
    checkOutput("zero_drained", out_valid, 0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
    tick();
    checkOutput("bp_ready_1", in_ready, 1);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    tick();
    checkOutput("bp_ready_2", in_ready, 0);
    checkOutput("bp_head_2", out_onehot, 4'b0010);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    tick();
    checkOutput("bp_held_ready", in_ready, 0);
    checkOutput("bp_stable_1", out_onehot, 4'b0010);
    tick();
    checkOutput("bp_stable_2", out_onehot, 4'b0010);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
    tick();
    checkOutput("bp_pop_1", out_onehot, 4'b0100);
    checkOutput("bp_ready_freed", in_ready, 1);
    tick();
    checkOutput("bp_pop_2", out_onehot, 4'b1000);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("bp_drained", out_valid, 0);
    checkOutput("bp_zero_cnt", zero_cnt, 1);

    $display("[TB] streaming");
    exp_zero = 1;
    for (int i = 0; i < 100; i++) begin
      str_code[i] = 2'($urandom_range(0, 3));
      str_any[i]  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, str_code[i], str_any[i], 1'b1);
      checkOutput("stream_in_ready", in_ready, 1);
      tick();
      // entry i-1 was popped on this edge
      if (i > 0 && !str_any[i-1] && exp_zero < 3) exp_zero++;
      exp_oh = str_any[i] ? (4'b0001 << str_code[i]) : 4'b0000;
      checkOutput("stream_valid", out_valid, 1);
      checkOutput("stream_onehot", out_onehot, exp_oh);
      checkOutput("stream_any", out_any, str_any[i]);
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    if (!str_any[99] && exp_zero < 3) exp_zero++;
    checkOutput("stream_drained", out_valid, 0);
    checkOutput("stream_zero_cnt", zero_cnt, exp_zero);

    $display("[TB] counter saturation");
    rst = 1'b1;
    #3 rst = 1'b0;
    tick();
    checkOutput("sat_start", zero_cnt, 0);
    sat_tab[0] = 2'd1; sat_tab[1] = 2'd2; sat_tab[2] = 2'd3;
    sat_tab[3] = 2'd3; sat_tab[4] = 2'd3;
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      tick();
      checkOutput("sat_zero_cnt", zero_cnt, sat_tab[i]);
    end
    checkOutput("sat_drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
